prod_accumulator: RTL

//   Downstream stage of the 4-bit shift-add multiplier: consumes a stream of
//   8-bit products and sums N_TERMS of them into one result (dot-product tail).

---
 rtl/prod_accumulator_pkg.sv | 11 +
 rtl/prod_accumulator_acc_controlador.sv | 79 +++++++
 rtl/prod_accumulator_registrador.sv | 22 ++
 rtl/prod_accumulator.sv | 88 ++++++++
 4 files changed

// File: rtl/prod_accumulator_pkg.sv
// Shared types for the multiplier/accumulator slice.
//   acc_state_t : product accumulator FSM states
package prod_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/prod_accumulator_acc_controlador.sv
// Control FSM and term counter for prod_accumulator.
//   clk_i, rst_i  : clock / asynchronous active-low reset
//   clear_i       : synchronous abort, active-high
//   prod_valid_i  : upstream product valid
//   sum_ready_i   : downstream consumer takes the result
//   state_o       : current FSM state
//   cnt_o         : products accepted into the current sum
//   prod_ready_o  : can accept a product this cycle
//   sum_valid_o   : finished result is being held
//   accept_o      : strobe, product is taken into the accumulator this cycle
//   clear_o       : strobe, datapath returns to zero (abort or delivery)
module acc_controlador
  import prod_accumulator_pkg::*;
#(
  parameter  int N_TERMS   = 4,
  localparam int CNT_WIDTH = $clog2(N_TERMS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 prod_valid_i,
  input  logic                 sum_ready_i,
  output acc_state_t           state_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 prod_ready_o,
  output logic                 sum_valid_o,
  output logic                 accept_o,
  output logic                 clear_o
);

  acc_state_t           state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next, cnt_inc;
  logic                 run;
  logic                 deliver;

  // ST_IDLE is the reset state, yet ready must stay low until the first edge
  // after reset release; run supplies that without an extra FSM state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    prod_ready_o = 1'b0;
    sum_valid_o  = 1'b0;

    unique case (state)
      ST_IDLE, ST_ACC: prod_ready_o = run;
      ST_DONE:         sum_valid_o  = 1'b1;
      default:         state_next   = ST_IDLE;
    endcase

    deliver  = sum_valid_o & sum_ready_i;
    accept_o = prod_valid_i & prod_ready_o & ~clear_i;
    clear_o  = clear_i | deliver;
    cnt_inc  = (state == ST_IDLE) ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);

    if (clear_o) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (accept_o) begin
      cnt_next   = cnt_inc;
      state_next = (cnt_inc == CNT_WIDTH'(N_TERMS)) ? ST_DONE : ST_ACC;
    end
  end

  assign state_o = state;
  assign cnt_o   = cnt;

endmodule

// File: rtl/prod_accumulator_registrador.sv
// Generic enabled register with asynchronous active-low reset to zero.
//   clk_i : clock (rising edge)
//   rst_i : asynchronous reset, active-low
//   en_i  : load d_i on the next rising edge
//   d_i   : data in  [W-1:0]
//   q_o   : data out [W-1:0]
module registrador #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/prod_accumulator.sv
// Sums N_TERMS unsigned products into one result, valid/ready on both sides.
//   clk_i         : clock, rising edge
//   rst_i         : asynchronous reset, active-low
//   clear_i       : synchronous abort/clear, active-high
//   prod_valid_i  : prod_i is valid
//   prod_i        : unsigned product [PROD_WIDTH-1:0]
//   prod_ready_o  : product accepted this cycle when valid
//   sum_valid_o   : sum_o holds a finished result
//   sum_ready_i   : consumer takes sum_o this cycle
//   sum_o         : accumulated result [ACC_WIDTH-1:0], modulo 2^ACC_WIDTH
//   term_cnt_o    : products accepted into the current sum
//   ovf_o         : sticky carry out of ACC_WIDTH during the current sum
module prod_accumulator
  import prod_accumulator_pkg::*;
#(
  parameter  int PROD_WIDTH = 8,
  parameter  int N_TERMS    = 4,
  parameter  int ACC_WIDTH  = 16,
  localparam int CNT_WIDTH  = $clog2(N_TERMS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  prod_valid_i,
  input  logic [PROD_WIDTH-1:0] prod_i,
  output logic                  prod_ready_o,
  output logic                  sum_valid_o,
  input  logic                  sum_ready_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic [CNT_WIDTH-1:0]  term_cnt_o,
  output logic                  ovf_o
);

  acc_state_t           state;
  logic                 accept, clear;
  logic [ACC_WIDTH-1:0] acc, acc_base, acc_d;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 ovf, ovf_d;

  acc_controlador #(
    .N_TERMS (N_TERMS)
  ) u_ctrl (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .prod_valid_i (prod_valid_i),
    .sum_ready_i  (sum_ready_i),
    .state_o      (state),
    .cnt_o        (term_cnt_o),
    .prod_ready_o (prod_ready_o),
    .sum_valid_o  (sum_valid_o),
    .accept_o     (accept),
    .clear_o      (clear)
  );

  // The first term loads rather than adds, so a sum never depends on the
  // accumulator having been zeroed beforehand.
  always_comb begin
    acc_base = (state == ST_IDLE) ? '0 : acc;
    acc_sum  = {1'b0, acc_base} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, prod_i};
    acc_d    = clear ? '0 : acc_sum[ACC_WIDTH-1:0];
    ovf_d    = clear ? 1'b0 : ((ovf & (state != ST_IDLE)) | acc_sum[ACC_WIDTH]);
  end

  registrador #(
    .W (ACC_WIDTH)
  ) u_acc_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (clear | accept),
    .d_i   (acc_d),
    .q_o   (acc)
  );

  registrador #(
    .W (1)
  ) u_ovf_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (clear | accept),
    .d_i   (ovf_d),
    .q_o   (ovf)
  );

  assign sum_o = acc;
  assign ovf_o = ovf;

endmodule
